serial_rx_monitor: RTL and testbench
====================================

SERIAL_RX_MONITOR -- requirements
Module: serial_rx_monitor

Interface
REQ-001 Parameter HALF_PERIOD, default 53, SHALL set half a bit time in clk cycles; a full bit time is 2*HALF_PERIOD; legal range 2..4095.
REQ-002 Port clk, input, 1, SHALL be the single clock; all logic is rising-edge.
REQ-003 Port reset, input, 1, SHALL be the reset: synchronous, active-high.
REQ-004 Port ser_rx, input, 1, SHALL be the asynchronous UART line (8N1, idle high), typically the SoC ser_tx.
REQ-005 Port data, output, 8, SHALL carry the received byte.
REQ-006 Port valid, output, 1, SHALL be high while data holds an unconsumed byte.
REQ-007 Port ready, input, 1, SHALL be the consumer accept; transfer occurs on a cycle with valid && ready.
REQ-008 Port frame_err, output, 1, SHALL pulse for one cycle on a bad stop bit.
REQ-009 Port overrun, output, 1, SHALL be a sticky flag for a dropped byte.
REQ-010 Port busy, output, 1, SHALL be high whenever the FSM is not IDLE.

Function
REQ-011 ser_rx SHALL pass through a 2-flop synchronizer (reset value 1); all following timing refers to the synchronizer output rx_s.
REQ-012 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-013 IDLE: rx_s sampled 0 at cycle T SHALL enter START with the bit counter cleared.
REQ-014 START: at T+HALF_PERIOD, rx_s==1 SHALL return to IDLE (glitch rejected, no output); rx_s==0 SHALL enter DATA.
REQ-015 DATA: bit i (i=0..7, LSB first) SHALL be sampled at T+HALF_PERIOD+2*HALF_PERIOD*(i+1) into a shift register; after bit 7 the FSM enters STOP.
REQ-016 STOP: the stop bit SHALL be sampled at T+19*HALF_PERIOD, after which the FSM returns to IDLE on the next cycle with no extra wait.
REQ-017 Stop==1 SHALL load data and assert valid on the cycle after the stop sample.
REQ-018 Stop==0 SHALL assert frame_err for exactly one cycle, and valid/data SHALL be unchanged.
REQ-019 valid SHALL clear on the cycle after valid && ready, and data SHALL stay stable while valid && !ready.
REQ-020 Completion with valid && !ready SHALL drop the new byte, keep the old data, and set overrun.
REQ-021 Completion in the same cycle as valid && ready SHALL load the new byte with valid held high and overrun unchanged.
REQ-022 The bit-timer counter SHALL be ceil(log2(2*HALF_PERIOD)) bits wide, reload on each sample point, and never wrap unobserved.
REQ-023 A frame_err frame SHALL still return to IDLE, and a new start SHALL be accepted whenever rx_s is low in IDLE.

Reset
REQ-024 Reset SHALL force: FSM=IDLE, synchronizer flops=1, counters=0, data=8'h00, valid=0, frame_err=0, overrun=0, busy=0.
REQ-025 Reset asserted mid-frame SHALL abandon the frame, and a frame starting after release SHALL decode normally.

Structure
REQ-026 Package serial_pkg SHALL hold the FSM state enum, the DEFAULT_HALF_PERIOD=53 constant and the frame bit count (8).
REQ-027 The 2-flop synchronizer SHALL be a separate sub-module, serial_sync.
REQ-028 The bit timer, FSM and output register SHALL live in serial_rx_monitor, with no other sub-modules.

Verification (HALF_PERIOD=4, bit time 8 cycles)
REQ-029 Frame 0x55 with stop=1 and ready=1 -> valid for 1 cycle, data=8'h55, frame_err=0, overrun=0.
REQ-030 Frame 0x41 with stop=0 -> frame_err 1-cycle pulse, valid stays 0, busy drops to 0 afterward.
REQ-031 ser_rx low for 2 cycles only -> busy high then low by T+5, no valid, no frame_err.
REQ-032 Back-to-back frames 0x12 then 0x34 with ready=0 -> data=8'h12, valid=1, overrun=1; after ready, valid=0.
REQ-033 Reset pulsed during DATA bit 3 -> all outputs at reset values; next frame 0xA5 -> data=8'hA5, valid=1.
REQ-034 ready asserted exactly on the completion cycle of a second byte 0x7E -> data=8'h7E, valid stays 1, overrun=0.

Source files
------------

// File: rtl/serial_pkg.sv
// serial_pkg: shared definitions for the serial receive monitor.
//   state_e             - receiver FSM states
//   DEFAULT_HALF_PERIOD - default half bit time in clk cycles
//   FRAME_BITS          - data bits per 8N1 frame
package serial_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_e;

  localparam int unsigned DEFAULT_HALF_PERIOD = 53;
  localparam int unsigned FRAME_BITS          = 8;

endpackage

// File: rtl/serial_sync.sv
// serial_sync: two-flop synchronizer for an asynchronous, idle-high line.
//   clk_i - clock
//   rst_i - synchronous active-high reset (both flops reset to 1)
//   d_i   - asynchronous input
//   q_o   - synchronized output
module serial_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/serial_rx_monitor.sv
// serial_rx_monitor: 8N1 UART receiver with a valid/ready output register.
//   HALF_PERIOD - half bit time in clk cycles (2..4095)
//   clk         - clock, rising edge
//   reset       - synchronous active-high reset
//   ser_rx      - asynchronous serial line, idle high
//   data        - received byte
//   valid       - data holds an unconsumed byte
//   ready       - consumer accept (transfer on valid && ready)
//   frame_err   - one-cycle pulse on a bad stop bit
//   overrun     - sticky: a completed byte was dropped
//   busy        - FSM not idle
module serial_rx_monitor
  import serial_pkg::*;
#(
  parameter int unsigned HALF_PERIOD = DEFAULT_HALF_PERIOD
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ser_rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned CW = $clog2(2 * HALF_PERIOD);
  localparam int unsigned BW = $clog2(FRAME_BITS);

  localparam logic [CW-1:0] HALF_RELOAD = CW'(HALF_PERIOD - 1);
  localparam logic [CW-1:0] FULL_RELOAD = CW'(2 * HALF_PERIOD - 1);
  localparam logic [BW-1:0] LAST_BIT    = BW'(FRAME_BITS - 1);

  logic rx_s;

  serial_sync u_sync (
    .clk_i (clk),
    .rst_i (reset),
    .d_i   (ser_rx),
    .q_o   (rx_s)
  );

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [7:0]            data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  ferr_q, ferr_d;
  logic                  ovr_q, ovr_d;
  logic                  sample;

  // The timer counts down to zero; zero marks a sample point and the
  // counter is reloaded there, so it never wraps.
  assign sample = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = 1'b0;
    ovr_d   = ovr_q;

    if (valid_q && ready) begin
      valid_d = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          state_d = ST_START;
          cnt_d   = HALF_RELOAD;
          bit_d   = '0;
        end
      end
      ST_START: begin
        if (sample) begin
          cnt_d = FULL_RELOAD;
          if (rx_s) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_DATA: begin
        if (sample) begin
          shift_d = {rx_s, shift_q[FRAME_BITS-1:1]};
          cnt_d   = FULL_RELOAD;
          if (bit_q == LAST_BIT) begin
            state_d = ST_STOP;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_STOP: begin
        if (sample) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          if (rx_s) begin
            // A same-cycle accept frees the register, so the new byte
            // replaces the consumed one and valid stays high.
            if (!valid_q || ready) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              ovr_d = 1'b1;
            end
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_serial_rx_monitor.sv
// tb_serial_rx_monitor: directed self-checking bench, HALF_PERIOD=4 (8-cycle bits).
module tb_serial_rx_monitor;

  logic       clk;
  logic       reset;
  logic       ser_rx;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Free-running event counters sampled at negedge; tasks take differences.
  int unsigned valid_cnt = 0;
  int unsigned fe_cnt    = 0;
  int unsigned busy_cnt  = 0;

  serial_rx_monitor #(.HALF_PERIOD(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .ser_rx    (ser_rx),
    .data      (data),
    .valid     (valid),
    .ready     (ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (valid)     valid_cnt <= valid_cnt + 1;
    if (frame_err) fe_cnt    <= fe_cnt + 1;
    if (busy)      busy_cnt  <= busy_cnt + 1;
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    ser_rx = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      ser_rx = b[i];
      repeat (8) @(negedge clk);
    end
    ser_rx = stop;
    repeat (8) @(negedge clk);
    ser_rx = 1'b1;
  endtask

  task automatic pulse_ready();
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    n_cmp++; if (data !== 8'h00) begin n_err++; $display("FAIL reset_data got=%h exp=00", data); end
    n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", valid); end
    n_cmp++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL reset_ferr got=%b exp=0", frame_err); end
    n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL reset_ovr got=%b exp=0", overrun); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
  endtask

  task automatic test_good_frame();
    int unsigned v0, f0;
    v0 = valid_cnt; f0 = fe_cnt;
    ready = 1'b1;
    send_byte(8'h55, 1'b1);
    repeat (4) @(negedge clk);
    ready = 1'b0;
    n_cmp++; if (valid_cnt - v0 !== 1) begin n_err++; $display("FAIL good_valid_cycles got=%0d exp=1", valid_cnt - v0); end
    n_cmp++; if (data !== 8'h55) begin n_err++; $display("FAIL good_data got=%h exp=55", data); end
    n_cmp++; if (fe_cnt - f0 !== 0) begin n_err++; $display("FAIL good_ferr got=%0d exp=0", fe_cnt - f0); end
    n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL good_ovr got=%b exp=0", overrun); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL good_busy got=%b exp=0", busy); end
  endtask

  task automatic test_frame_error();
    int unsigned v0, f0;
    v0 = valid_cnt; f0 = fe_cnt;
    send_byte(8'h41, 1'b0);
    repeat (12) @(negedge clk);
    n_cmp++; if (fe_cnt - f0 !== 1) begin n_err++; $display("FAIL ferr_pulse got=%0d exp=1", fe_cnt - f0); end
    n_cmp++; if (valid_cnt - v0 !== 0) begin n_err++; $display("FAIL ferr_valid got=%0d exp=0", valid_cnt - v0); end
    n_cmp++; if (data !== 8'h55) begin n_err++; $display("FAIL ferr_data got=%h exp=55", data); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ferr_busy got=%b exp=0", busy); end
  endtask

  task automatic test_glitch();
    int unsigned v0, f0, b0;
    v0 = valid_cnt; f0 = fe_cnt; b0 = busy_cnt;
    ser_rx = 1'b0;
    repeat (2) @(negedge clk);
    ser_rx = 1'b1;
    repeat (12) @(negedge clk);
    n_cmp++; if (busy_cnt - b0 !== 4) begin n_err++; $display("FAIL glitch_busy_cycles got=%0d exp=4", busy_cnt - b0); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL glitch_busy got=%b exp=0", busy); end
    n_cmp++; if (valid_cnt - v0 !== 0) begin n_err++; $display("FAIL glitch_valid got=%0d exp=0", valid_cnt - v0); end
    n_cmp++; if (fe_cnt - f0 !== 0) begin n_err++; $display("FAIL glitch_ferr got=%0d exp=0", fe_cnt - f0); end
  endtask

  task automatic test_back_to_back();
    ready = 1'b0;
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    repeat (4) @(negedge clk);
    n_cmp++; if (data !== 8'h12) begin n_err++; $display("FAIL b2b_data got=%h exp=12", data); end
    n_cmp++; if (valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid got=%b exp=1", valid); end
    n_cmp++; if (overrun !== 1'b1) begin n_err++; $display("FAIL b2b_ovr got=%b exp=1", overrun); end
    pulse_ready();
    n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL b2b_valid_after_ready got=%b exp=0", valid); end
    n_cmp++; if (overrun !== 1'b1) begin n_err++; $display("FAIL b2b_ovr_sticky got=%b exp=1", overrun); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b;
    b = 8'hA5;
    ser_rx = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      ser_rx = b[i];
      repeat (8) @(negedge clk);
    end
    ser_rx = b[3];
    repeat (4) @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL mid_busy got=%b exp=1", busy); end
    reset = 1'b1;
    ser_rx = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    send_byte(8'hA5, 1'b1);
    repeat (4) @(negedge clk);
    n_cmp++; if (data !== 8'hA5) begin n_err++; $display("FAIL post_reset_data got=%h exp=a5", data); end
    n_cmp++; if (valid !== 1'b1) begin n_err++; $display("FAIL post_reset_valid got=%b exp=1", valid); end
  endtask

  task automatic test_ready_on_completion();
    pulse_ready();
    send_byte(8'h3C, 1'b1);
    repeat (2) @(negedge clk);
    n_cmp++; if (data !== 8'h3C) begin n_err++; $display("FAIL first_data got=%h exp=3c", data); end
    // Stop sample of the next frame lands on the posedge after the 78th
    // negedge from its start edge (2-flop sync + 19 half periods).
    fork
      send_byte(8'h7E, 1'b1);
      begin
        repeat (78) @(negedge clk);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
      end
    join
    repeat (3) @(negedge clk);
    n_cmp++; if (data !== 8'h7E) begin n_err++; $display("FAIL coinc_data got=%h exp=7e", data); end
    n_cmp++; if (valid !== 1'b1) begin n_err++; $display("FAIL coinc_valid got=%b exp=1", valid); end
    n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL coinc_ovr got=%b exp=0", overrun); end
  endtask

  initial begin
    reset  = 1'b1;
    ready  = 1'b0;
    ser_rx = 1'b1;
    repeat (3) @(negedge clk);
    test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    test_good_frame();
    test_frame_error();
    test_glitch();
    test_back_to_back();
    test_reset_mid_frame();
    test_ready_on_completion();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
